// File: rtl/mod_pow2_scaler_pkg.sv
// Shared FSM state encodings and step-select constants for the power-of-two
// modular scaler.
package mod_pow2_scaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Which step result is written back to the accumulator in RUN.
  typedef enum logic {
    STEP_QUAD = 1'b0,
    STEP_DBL  = 1'b1
  } step_sel_e;

  localparam int unsigned DEFAULT_BITWIDTH = 32;
  localparam int unsigned DEFAULT_SHIFTW   = 6;

endpackage : mod_pow2_scaler_pkg

// File: rtl/mod_pow2_scaler_step.sv
// Modular step datapaths: mod_doubler computes 2x mod m, and mod_quadrupler
// chains two doublers to get 4x mod m in one cycle. Both require x < m.
module mod_doubler #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] x_i,
  input  logic [BITWIDTH-1:0] m_i,
  output logic [BITWIDTH-1:0] y_o
);

  logic [BITWIDTH:0] twice;
  logic              ge_mod;

  // The extra top bit keeps 2x exact even when m is close to 2^BITWIDTH.
  assign twice  = {x_i, 1'b0};
  assign ge_mod = (twice >= {1'b0, m_i});
  assign y_o    = twice[BITWIDTH-1:0] - (ge_mod ? m_i : '0);

endmodule : mod_doubler

module mod_quadrupler #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] x_i,
  input  logic [BITWIDTH-1:0] m_i,
  output logic [BITWIDTH-1:0] y_o
);

  logic [BITWIDTH-1:0] mid;

  mod_doubler #(.BITWIDTH(BITWIDTH)) u_dbl_first (
    .x_i (x_i),
    .m_i (m_i),
    .y_o (mid)
  );

  mod_doubler #(.BITWIDTH(BITWIDTH)) u_dbl_second (
    .x_i (mid),
    .m_i (m_i),
    .y_o (y_o)
  );

endmodule : mod_quadrupler

// File: rtl/mod_pow2_scaler.sv
// Iterative (iData * 2^iShift) mod iMod: consumes the shift two bits per cycle
// with the quadrupler and finishes an odd remainder with a single doubling.
module mod_pow2_scaler
  import mod_pow2_scaler_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH,
  parameter int unsigned SHIFTW   = DEFAULT_SHIFTW
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [SHIFTW-1:0]   iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic [BITWIDTH-1:0] mod_q, mod_d;
  logic [SHIFTW-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [BITWIDTH-1:0] dbl_y;
  logic [BITWIDTH-1:0] quad_y;
  step_sel_e           step_sel;
  logic                bad_operands;

  mod_doubler #(.BITWIDTH(BITWIDTH)) u_doubler (
    .x_i (acc_q),
    .m_i (mod_q),
    .y_o (dbl_y)
  );

  mod_quadrupler #(.BITWIDTH(BITWIDTH)) u_quadrupler (
    .x_i (acc_q),
    .m_i (mod_q),
    .y_o (quad_y)
  );

  assign step_sel     = (cnt_q == SHIFTW'(1)) ? STEP_DBL : STEP_QUAD;
  assign bad_operands = (iMod == '0) || (iData >= iMod);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          mod_d = iMod;
          acc_d = iData;
          cnt_d = iShift;
          if (bad_operands) begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (iShift == '0) begin
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = (step_sel == STEP_DBL) ? dbl_y : quad_y;
        cnt_d = (cnt_q >= SHIFTW'(2)) ? (cnt_q - SHIFTW'(2)) : '0;
        if (cnt_q <= SHIFTW'(2)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (iReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs come straight from registers; acc is untouched in DONE, so the
  // result stays stable under backpressure.
  assign oReady = (state_q == ST_IDLE);
  assign oValid = (state_q == ST_DONE);
  assign oData  = acc_q;
  assign oErr   = err_q;

endmodule : mod_pow2_scaler
